// File: rtl/shift_sequencer_if.sv
// Command/result interface of the shift sequencer.
//   cmd_valid/cmd_ready : command handshake, accepted when both are 1 on a rising edge
//   cmd_op              : 00 LOAD, 01 LOAD+LSR, 10 LOAD+ASR, 11 in-place ASR
//   cmd_data            : load value
//   cmd_count           : number of shifts
//   cmd_sin             : serial-in bit used during LSR
//   res_valid/res_data  : one-cycle result strobe and held result
//   busy                : sequencer not idle
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_sin;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             busy;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_sin,
        input  cmd_ready, res_valid, res_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count, cmd_sin,
        output cmd_ready, res_valid, res_data, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// Sequencer driving a downstream multi-function register (hold/load/LSR/ASR).
// Accepts a command, loads and/or shifts the register the requested number
// of times, then captures the register output as the result.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   cmd          : command/result interface (slave side)
//   reg_e        : register enable
//   reg_f1/f0    : register function (00 hold, 01 load, 10 LSR with sin, 11 ASR)
//   reg_sin      : register serial-in
//   reg_d        : register parallel data
//   q_in         : register output q
//
// state   | meaning
// IDLE    | ready for a command, register held
// LOAD    | parallel-load latched data into the register
// SHIFT   | one shift per cycle until the remaining count runs out
// CAPTURE | register settled; result captured on the leaving edge
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    shift_sequencer_if.slave   cmd,
    output logic               reg_e,
    output logic               reg_f1,
    output logic               reg_f0,
    output logic               reg_sin,
    output logic [WIDTH-1:0]   reg_d,
    input  logic [WIDTH-1:0]   q_in
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        SHIFT   = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_LSR  = 2'b01;
    localparam logic [1:0] OP_ASR  = 2'b11;

    state_t           state, next_state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic             sin_q;
    logic [CNT_W-1:0] remaining;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic [1:0]       func;

    wire accept = (state == IDLE) && cmd.cmd_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= '0;
            data_q      <= '0;
            sin_q       <= 1'b0;
            remaining   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state       <= next_state;
            res_valid_q <= 1'b0;
            if (accept) begin
                op_q      <= cmd.cmd_op;
                data_q    <= cmd.cmd_data;
                sin_q     <= cmd.cmd_sin;
                remaining <= cmd.cmd_count;
            end
            if (state == SHIFT) begin
                remaining <= remaining - 1'b1;
            end
            if (state == CAPTURE) begin
                res_data_q  <= q_in;
                res_valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    if (cmd.cmd_op != OP_ASR)
                        next_state = LOAD;
                    else if (cmd.cmd_count != '0)
                        next_state = SHIFT;
                    else
                        next_state = CAPTURE;
                end
            end
            LOAD: begin
                if (op_q != OP_LOAD && remaining != '0)
                    next_state = SHIFT;
                else
                    next_state = CAPTURE;
            end
            SHIFT: begin
                // <= 1 rather than == 1 so a corrupted zero count cannot spin
                if (remaining <= CNT_W'(1))
                    next_state = CAPTURE;
            end
            CAPTURE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        reg_e   = 1'b0;
        func    = 2'b00;
        reg_sin = 1'b0;
        reg_d   = '0;
        unique case (state)
            LOAD: begin
                reg_e = 1'b1;
                func  = 2'b01;
                reg_d = data_q;
            end
            SHIFT: begin
                reg_e = 1'b1;
                if (op_q == OP_LSR) begin
                    func    = 2'b10;
                    reg_sin = sin_q;
                end else begin
                    func = 2'b11;
                end
            end
            default: ;
        endcase
    end

    assign reg_f1        = func[1];
    assign reg_f0        = func[0];
    assign cmd.cmd_ready = (state == IDLE);
    assign cmd.busy      = (state != IDLE);
    assign cmd.res_valid = res_valid_q;
    assign cmd.res_data  = res_data_q;
endmodule
